// File: rtl/sync_pack_fifo_if.sv
// Write/read bundle for sync_pack_fifo: the master side issues writes, flushes and reads,
// and the slave side (the FIFO) returns status, water levels and read beats.
interface sync_pack_fifo_if #(
    parameter int WR_DATA_WIDTH  = 32,
    parameter int RATIO          = 8,
    parameter int RD_DEPTH_WIDTH = 8
);
    localparam int CW             = $clog2(RATIO);
    localparam int WR_DEPTH_WIDTH = RD_DEPTH_WIDTH + CW;
    localparam int RD_DATA_WIDTH  = WR_DATA_WIDTH * RATIO;

    logic                     wr_en;
    logic [WR_DATA_WIDTH-1:0] wr_data;
    logic                     wr_flush;
    logic                     wr_full;
    logic                     almost_full;
    logic [WR_DEPTH_WIDTH:0]  wr_water_level;
    logic                     rd_en;
    logic [RD_DATA_WIDTH-1:0] rd_data;
    logic [CW:0]              rd_cnt;
    logic                     rd_valid;
    logic                     rd_empty;
    logic                     almost_empty;
    logic [RD_DEPTH_WIDTH:0]  rd_water_level;

    modport master (
        output wr_en, wr_data, wr_flush, rd_en,
        input  wr_full, almost_full, wr_water_level,
        input  rd_data, rd_cnt, rd_valid, rd_empty, almost_empty, rd_water_level
    );

    modport slave (
        input  wr_en, wr_data, wr_flush, rd_en,
        output wr_full, almost_full, wr_water_level,
        output rd_data, rd_cnt, rd_valid, rd_empty, almost_empty, rd_water_level
    );
endinterface

// File: rtl/sync_pack_fifo.sv
// Single-clock width-converting FIFO: packs RATIO narrow words into one wide beat, with a
// flush that commits a zero-padded partial beat tagged by its valid-word count.
module sync_pack_fifo #(
    parameter int WR_DATA_WIDTH    = 32,
    parameter int RATIO            = 8,
    parameter int RD_DEPTH_WIDTH   = 8,
    parameter int ALMOST_FULL_NUM  = 2040,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic            clk,
    input  logic            rst,
    sync_pack_fifo_if.slave bus
);
    localparam int CW             = $clog2(RATIO);
    localparam int WR_DEPTH_WIDTH = RD_DEPTH_WIDTH + CW;
    localparam int RD_DATA_WIDTH  = WR_DATA_WIDTH * RATIO;
    localparam int DEPTH          = 2 ** RD_DEPTH_WIDTH;
    localparam int TAG_W          = CW + 1;
    localparam int CNT_W          = RD_DEPTH_WIDTH + 1;
    localparam int WR_LVL_W       = WR_DEPTH_WIDTH + 1;

    localparam logic [CNT_W-1:0]          DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]          CNT_ONE   = CNT_W'(1);
    localparam logic [RD_DEPTH_WIDTH-1:0] PTR_ONE   = RD_DEPTH_WIDTH'(1);
    localparam logic [CW-1:0]             LAST_LANE = CW'(RATIO - 1);
    localparam logic [CW-1:0]             LANE_ONE  = CW'(1);
    localparam logic [TAG_W-1:0]          FULL_TAG  = TAG_W'(RATIO);

    typedef enum logic [0:0] {
        ST_FILL       = 1'b0,
        ST_FLUSH_PEND = 1'b1
    } state_t;

    // Beat memory and its valid-word tags (not reset)
    logic [RD_DATA_WIDTH-1:0] mem_data_r [DEPTH];
    logic [TAG_W-1:0]         mem_tag_r  [DEPTH];

    state_t                              state_r, state_nxt_s;
    logic [RATIO-1:0][WR_DATA_WIDTH-1:0] pack_r, pack_nxt_s;
    logic [RATIO-1:0][WR_DATA_WIDTH-1:0] commit_data_s;
    logic [CW-1:0]                       pack_cnt_r, pack_cnt_nxt_s;
    logic [TAG_W-1:0]                    fill_cnt_s, commit_tag_s;
    logic [RD_DEPTH_WIDTH-1:0]           wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [CNT_W-1:0]                    mem_cnt_r, mem_cnt_nxt_s;
    logic [WR_LVL_W-1:0]                 wr_level_r, wr_level_nxt_s;
    logic                                wr_full_r, almost_full_r, rd_empty_r, almost_empty_r;
    logic [RD_DATA_WIDTH-1:0]            rd_data_r;
    logic [TAG_W-1:0]                    rd_cnt_r;
    logic                                rd_valid_r;
    logic                                wr_acc_s, rd_acc_s, mem_full_s, commit_s;

    assign wr_acc_s   = bus.wr_en & ~wr_full_r;
    assign rd_acc_s   = bus.rd_en & ~rd_empty_r;
    assign mem_full_s = (mem_cnt_r == DEPTH_CNT);
    assign fill_cnt_s = {1'b0, pack_cnt_r} + {{CW{1'b0}}, wr_acc_s};

    // Beat being committed: held lanes, plus this cycle's accepted word, upper lanes zeroed
    always_comb begin
        commit_data_s = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) < pack_cnt_r) begin
                commit_data_s[k] = pack_r[k];
            end else if ((CW'(k) == pack_cnt_r) && wr_acc_s) begin
                commit_data_s[k] = bus.wr_data;
            end else begin
                commit_data_s[k] = '0;
            end
        end
    end

    // Packing FSM: next state, commit decision and pack-lane updates
    always_comb begin
        state_nxt_s    = state_r;
        commit_s       = 1'b0;
        commit_tag_s   = '0;
        pack_nxt_s     = pack_r;
        pack_cnt_nxt_s = pack_cnt_r;
        case (state_r)
            ST_FILL: begin
                if (wr_acc_s) begin
                    pack_nxt_s[pack_cnt_r] = bus.wr_data;
                end else begin
                    pack_nxt_s = pack_r;
                end
                if (wr_acc_s && (pack_cnt_r == LAST_LANE)) begin
                    commit_s       = 1'b1;
                    commit_tag_s   = FULL_TAG;
                    pack_cnt_nxt_s = '0;
                end else if (bus.wr_flush && (fill_cnt_s != '0)) begin
                    // A flush into a full memory parks the partial beat until a slot frees up
                    if (mem_full_s) begin
                        state_nxt_s    = ST_FLUSH_PEND;
                        pack_cnt_nxt_s = fill_cnt_s[CW-1:0];
                    end else begin
                        commit_s       = 1'b1;
                        commit_tag_s   = fill_cnt_s;
                        pack_cnt_nxt_s = '0;
                    end
                end else if (wr_acc_s) begin
                    pack_cnt_nxt_s = pack_cnt_r + LANE_ONE;
                end else begin
                    pack_cnt_nxt_s = pack_cnt_r;
                end
            end
            ST_FLUSH_PEND: begin
                if (!mem_full_s || rd_acc_s) begin
                    commit_s       = 1'b1;
                    commit_tag_s   = {1'b0, pack_cnt_r};
                    pack_cnt_nxt_s = '0;
                    state_nxt_s    = ST_FILL;
                end else begin
                    state_nxt_s    = ST_FLUSH_PEND;
                end
            end
            default: begin
                state_nxt_s    = ST_FILL;
                pack_cnt_nxt_s = '0;
            end
        endcase
    end

    // Occupancy and pointer bookkeeping
    always_comb begin
        case ({commit_s, rd_acc_s})
            2'b10:   mem_cnt_nxt_s = mem_cnt_r + CNT_ONE;
            2'b01:   mem_cnt_nxt_s = mem_cnt_r - CNT_ONE;
            default: mem_cnt_nxt_s = mem_cnt_r;
        endcase
        if (commit_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_acc_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        wr_level_nxt_s = {mem_cnt_nxt_s, {CW{1'b0}}} + WR_LVL_W'(pack_cnt_nxt_s);
    end

    // Control state, flags, water levels and read output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_FILL;
            pack_r         <= '0;
            pack_cnt_r     <= '0;
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            mem_cnt_r      <= '0;
            wr_level_r     <= '0;
            wr_full_r      <= 1'b0;
            almost_full_r  <= 1'b0;
            rd_empty_r     <= 1'b1;
            almost_empty_r <= 1'b1;
            rd_data_r      <= '0;
            rd_cnt_r       <= '0;
            rd_valid_r     <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            pack_r         <= pack_nxt_s;
            pack_cnt_r     <= pack_cnt_nxt_s;
            wr_ptr_r       <= wr_ptr_nxt_s;
            rd_ptr_r       <= rd_ptr_nxt_s;
            mem_cnt_r      <= mem_cnt_nxt_s;
            wr_level_r     <= wr_level_nxt_s;
            wr_full_r      <= (state_nxt_s == ST_FLUSH_PEND) |
                              ((mem_cnt_nxt_s == DEPTH_CNT) & (pack_cnt_nxt_s == LAST_LANE));
            almost_full_r  <= (wr_level_nxt_s >= WR_LVL_W'(ALMOST_FULL_NUM));
            rd_empty_r     <= (mem_cnt_nxt_s == '0);
            almost_empty_r <= (mem_cnt_nxt_s <= CNT_W'(ALMOST_EMPTY_NUM));
            rd_valid_r     <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data_r <= mem_data_r[rd_ptr_r];
                rd_cnt_r  <= mem_tag_r[rd_ptr_r];
            end
        end
    end

    // Beat memory write port; a same-edge read of a full memory still sees the old head
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_data_r[wr_ptr_r] <= commit_data_s;
            mem_tag_r[wr_ptr_r]  <= commit_tag_s;
        end
    end

    assign bus.wr_full        = wr_full_r;
    assign bus.almost_full    = almost_full_r;
    assign bus.wr_water_level = wr_level_r;
    assign bus.rd_data        = rd_data_r;
    assign bus.rd_cnt         = rd_cnt_r;
    assign bus.rd_valid       = rd_valid_r;
    assign bus.rd_empty       = rd_empty_r;
    assign bus.almost_empty   = almost_empty_r;
    assign bus.rd_water_level = mem_cnt_r;
endmodule

// File: tb/tb_sync_pack_fifo.sv
// Self-checking bench for sync_pack_fifo: a directed vector table, corner-case sequences and
// randomized traffic compared against a queue-based model of the packing FIFO.
module tb_sync_pack_fifo;
    localparam int W     = 32;
    localparam int RATIO = 8;
    localparam int DEPTH = 256;
    localparam int AF    = 2040;
    localparam int AE    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_pack_fifo_if #(.WR_DATA_WIDTH(W), .RATIO(RATIO), .RD_DEPTH_WIDTH(8)) bus ();

    sync_pack_fifo #(
        .WR_DATA_WIDTH(W), .RATIO(RATIO), .RD_DEPTH_WIDTH(8),
        .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [W*RATIO-1:0] data;
        int                 cnt;
    } beat_t;

    typedef struct {
        bit                 we;
        logic [W-1:0]       wd;
        bit                 fl;
        bit                 re;
        bit                 e_full;
        bit                 e_empty;
        bit                 e_valid;
        int                 e_cnt;
        int                 e_wlvl;
        int                 e_rlvl;
        logic [W*RATIO-1:0] e_data;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: plain queues of pending words and stored beats
    logic [W-1:0]       m_pack[$];
    beat_t              m_beats[$];
    bit                 m_pend;
    logic [W*RATIO-1:0] m_data;
    int                 m_cnt;
    bit                 m_valid;

    task automatic chk(input string name, input logic [W*RATIO-1:0] act, input logic [W*RATIO-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_pack.delete();
        m_beats.delete();
        m_pend  = 1'b0;
        m_data  = '0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    task automatic model_commit();
        beat_t b;
        b.data = '0;
        foreach (m_pack[i]) b.data[i*W +: W] = m_pack[i];
        b.cnt = m_pack.size();
        m_beats.push_back(b);
        m_pack.delete();
    endtask

    function automatic bit model_full();
        return m_pend || (m_beats.size() == DEPTH && m_pack.size() == RATIO - 1);
    endfunction

    task automatic check_model(input string tag);
        int wl;
        wl = m_beats.size() * RATIO + m_pack.size();
        chk({tag, "_wr_full"},      bus.wr_full,        model_full());
        chk({tag, "_almost_full"},  bus.almost_full,    wl >= AF);
        chk({tag, "_wr_level"},     bus.wr_water_level, wl);
        chk({tag, "_rd_empty"},     bus.rd_empty,       m_beats.size() == 0);
        chk({tag, "_almost_empty"}, bus.almost_empty,   m_beats.size() <= AE);
        chk({tag, "_rd_level"},     bus.rd_water_level, m_beats.size());
        chk({tag, "_rd_valid"},     bus.rd_valid,       m_valid);
        chk({tag, "_rd_cnt"},       bus.rd_cnt,         m_cnt);
        chk({tag, "_rd_data"},      bus.rd_data,        m_data);
    endtask

    // One clock: drive inputs, advance the model across the edge, compare at the falling edge
    task automatic step(input bit we, input logic [W-1:0] wd, input bit fl, input bit re, input string tag);
        bit    wacc, racc;
        int    pre;
        beat_t b;
        wacc = we && !model_full();
        racc = re && (m_beats.size() != 0);
        pre  = m_beats.size();
        bus.wr_en = we; bus.wr_data = wd; bus.wr_flush = fl; bus.rd_en = re;
        @(posedge clk);
        m_valid = 1'b0;
        if (racc) begin
            b       = m_beats.pop_front();
            m_data  = b.data;
            m_cnt   = b.cnt;
            m_valid = 1'b1;
        end
        if (m_pend) begin
            if (pre < DEPTH || racc) begin
                model_commit();
                m_pend = 1'b0;
            end
        end else begin
            if (wacc) m_pack.push_back(wd);
            if (m_pack.size() == RATIO) begin
                model_commit();
            end else if (fl && m_pack.size() > 0) begin
                if (pre == DEPTH) m_pend = 1'b1;
                else model_commit();
            end
        end
        @(negedge clk);
        check_model(tag);
        bus.wr_en = 1'b0; bus.wr_flush = 1'b0; bus.rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        model_clear();
        check_model("reset");
        rst = 1'b0;
    endtask

    function automatic vec_t mkv(bit we, logic [W-1:0] wd, bit fl, bit re, bit f, bit e, bit v,
                                 int c, int wlv, int rlv, logic [W*RATIO-1:0] d);
        vec_t t;
        t.we = we; t.wd = wd; t.fl = fl; t.re = re;
        t.e_full = f; t.e_empty = e; t.e_valid = v; t.e_cnt = c;
        t.e_wlvl = wlv; t.e_rlvl = rlv; t.e_data = d;
        return t;
    endfunction

    vec_t               tbl[$];
    logic [W*RATIO-1:0] d0, dabc, dd;
    logic [W-1:0]       wa, wb, wc, wdd;

    initial begin
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_flush = 1'b0; bus.rd_en = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Directed table: full-beat packing, partial flush, idle flush, empty read, write+flush
        wa = 32'hA0A0_0001; wb = 32'hB0B0_0002; wc = 32'hC0C0_0003; wdd = 32'hD0D0_0004;
        d0 = '0;
        for (int k = 0; k < RATIO; k++) d0[k*W +: W] = W'(k);
        dabc = '0; dabc[0 +: W] = wa; dabc[W +: W] = wb; dabc[2*W +: W] = wc;
        dd = '0; dd[0 +: W] = wdd;
        for (int k = 0; k < 7; k++) tbl.push_back(mkv(1, W'(k), 0, 0, 0, 1, 0, 0, k + 1, 0, '0));
        tbl.push_back(mkv(1, 32'd7, 0, 0, 0, 0, 0, 0, 8, 1, '0));
        tbl.push_back(mkv(0, '0, 0, 1, 0, 1, 1, 8, 0, 0, d0));
        tbl.push_back(mkv(1, wa, 0, 0, 0, 1, 0, 8, 1, 0, d0));
        tbl.push_back(mkv(1, wb, 0, 0, 0, 1, 0, 8, 2, 0, d0));
        tbl.push_back(mkv(1, wc, 0, 0, 0, 1, 0, 8, 3, 0, d0));
        tbl.push_back(mkv(0, '0, 1, 0, 0, 0, 0, 8, 8, 1, d0));
        tbl.push_back(mkv(0, '0, 1, 0, 0, 0, 0, 8, 8, 1, d0));
        tbl.push_back(mkv(0, '0, 0, 1, 0, 1, 1, 3, 0, 0, dabc));
        tbl.push_back(mkv(0, '0, 0, 1, 0, 1, 0, 3, 0, 0, dabc));
        tbl.push_back(mkv(1, wdd, 1, 0, 0, 0, 0, 3, 8, 1, dabc));
        tbl.push_back(mkv(0, '0, 0, 1, 0, 1, 1, 1, 0, 0, dd));
        foreach (tbl[i]) begin
            bus.wr_en = tbl[i].we; bus.wr_data = tbl[i].wd;
            bus.wr_flush = tbl[i].fl; bus.rd_en = tbl[i].re;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_wr_full", i),  bus.wr_full,        tbl[i].e_full);
            chk($sformatf("tbl%0d_rd_empty", i), bus.rd_empty,       tbl[i].e_empty);
            chk($sformatf("tbl%0d_rd_valid", i), bus.rd_valid,       tbl[i].e_valid);
            chk($sformatf("tbl%0d_rd_cnt", i),   bus.rd_cnt,         tbl[i].e_cnt);
            chk($sformatf("tbl%0d_wr_level", i), bus.wr_water_level, tbl[i].e_wlvl);
            chk($sformatf("tbl%0d_rd_level", i), bus.rd_water_level, tbl[i].e_rlvl);
            chk($sformatf("tbl%0d_rd_data", i),  bus.rd_data,        tbl[i].e_data);
            chk($sformatf("tbl%0d_af_ae", i),    {bus.almost_full, bus.almost_empty}, 2'b01);
        end
        bus.wr_en = 1'b0; bus.wr_flush = 1'b0; bus.rd_en = 1'b0;
        do_reset();

        // Fill to 2055 words, check almost_full threshold, dropped write, and read-unblock
        for (int i = 1; i <= 2055; i++) begin
            step(1, W'(i), 0, 0, "fill");
            if (i == 2039) chk("af_below", bus.almost_full, 1'b0);
            if (i == 2040) chk("af_at", bus.almost_full, 1'b1);
        end
        chk("full_at_2055", bus.wr_full, 1'b1);
        chk("level_2055", bus.wr_water_level, 2055);
        step(1, 32'hDEAD_BEEF, 0, 0, "drop");
        chk("drop_level", bus.wr_water_level, 2055);
        step(0, '0, 0, 1, "unblock_rd");
        chk("unblock_full", bus.wr_full, 1'b0);
        step(1, 32'h0000_0808, 0, 0, "complete");
        chk("complete_rd_level", bus.rd_water_level, 256);
        chk("complete_wr_level", bus.wr_water_level, 2048);

        // Flush into a full memory parks until a read frees the slot
        step(1, 32'h1111_0001, 0, 0, "pend_w1");
        step(1, 32'h1111_0002, 0, 0, "pend_w2");
        step(1, 32'h1111_0003, 1, 0, "pend_flush");
        chk("pend_full", bus.wr_full, 1'b1);
        step(0, '0, 1, 0, "pend_hold");
        chk("pend_hold_full", bus.wr_full, 1'b1);
        step(0, '0, 0, 1, "pend_release");
        chk("release_full", bus.wr_full, 1'b0);
        chk("release_rd_level", bus.rd_water_level, 256);
        for (int i = 0; i < 256; i++) step(0, '0, 0, 1, "drain");
        chk("last_beat_cnt", bus.rd_cnt, 3);
        chk("drained_empty", bus.rd_empty, 1'b1);

        // Commit coinciding with a read keeps the level at one beat
        do_reset();
        for (int i = 0; i < 15; i++) step(1, W'(i + 100), 0, 0, "sim_w");
        step(1, 32'd115, 0, 1, "sim_rw");
        chk("sim_rd_level", bus.rd_water_level, 1);
        chk("sim_rd_valid", bus.rd_valid, 1'b1);

        // Asynchronous reset mid-operation with 100 beats stored and 5 words packed
        do_reset();
        for (int i = 0; i < 101 * RATIO + 4; i++) step(1, $urandom, 0, 0, "pre_rst");
        step(1, $urandom, 0, 1, "pre_rst_rd");
        chk("pre_rst_level", bus.rd_water_level, 100);
        #2 rst = 1'b1;
        #1;
        chk("arst_wr_full", bus.wr_full, 1'b0);
        chk("arst_af", bus.almost_full, 1'b0);
        chk("arst_wr_level", bus.wr_water_level, 0);
        chk("arst_rd_empty", bus.rd_empty, 1'b1);
        chk("arst_ae", bus.almost_empty, 1'b1);
        chk("arst_rd_level", bus.rd_water_level, 0);
        chk("arst_rd_valid", bus.rd_valid, 1'b0);
        chk("arst_rd_cnt", bus.rd_cnt, 0);
        chk("arst_rd_data", bus.rd_data, '0);
        @(negedge clk);
        do_reset();

        // Randomized traffic: fill past full, hover near full, then drain
        for (int c = 0; c < 2600; c++)
            step(1'b1, $urandom, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3, "rnd_fill");
        for (int c = 0; c < 1500; c++)
            step($urandom_range(0, 99) < 90, $urandom, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 12, "rnd_mid");
        for (int c = 0; c < 2500; c++)
            step($urandom_range(0, 99) < 20, $urandom, $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 90, "rnd_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
